// File: rtl/dds_multiwave_osc_if.sv
// Control and sample bus of one DDS oscillator voice.
// The sequencer/test side drives the master modport and the oscillator uses the slave modport.
interface dds_multiwave_osc_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int VOL_WIDTH   = 6
);
  logic                   sample_en;
  logic [PHASE_WIDTH-1:0] freq_word;
  logic [1:0]             wave_sel;
  logic [7:0]             duty;
  logic [VOL_WIDTH-1:0]   vol;
  logic                   sync;
  logic [OUT_WIDTH-1:0]   wave_out;
  logic                   out_valid;
  logic                   wrap;
  logic [PHASE_WIDTH-1:0] phase_out;

  modport master (
    output sample_en, freq_word, wave_sel, duty, vol, sync,
    input  wave_out, out_valid, wrap, phase_out
  );

  modport slave (
    input  sample_en, freq_word, wave_sel, duty, vol, sync,
    output wave_out, out_valid, wrap, phase_out
  );
endinterface

// File: rtl/dds_multiwave_osc.sv
// Multi-waveform DDS voice: saw/square/triangle/noise derived from the phase accumulator,
// two-stage pipeline (waveform at the strobe edge, volume scaling one edge later).
module dds_multiwave_osc #(
  parameter int PHASE_WIDTH = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int VOL_WIDTH   = 6
) (
  input logic               clk,
  input logic               rst_active_low,
  dds_multiwave_osc_if.slave bus
);

  localparam int PW = PHASE_WIDTH;
  localparam int W  = OUT_WIDTH;
  localparam int VW = VOL_WIDTH;
  localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_NOISE  = 2'd3
  } wave_e;

  logic [PW-1:0] phase_q;
  wave_e         active_wave_q;
  logic [15:0]   lfsr_q;
  logic [W-1:0]  s1_wave_q;
  logic          s1_valid_q;
  logic [W-1:0]  wave_out_q;
  logic          out_valid_q;
  logic          wrap_q;

  logic [PW:0]   sum_d;
  logic [15:0]   lfsr_d;
  logic [W-1:0]  u, t;
  logic [W-1:0]  saw_val, sq_val, tri_val, noise_val, wave_d;
  logic signed [W+VW:0] prod;
  logic [W-1:0]  scaled_d;

  assign sum_d  = {1'b0, phase_q} + {1'b0, bus.freq_word};
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Waveforms are offset-binary patterns reinterpreted as signed two's complement.
  always_comb begin
    u         = phase_q[PW-1 -: W];
    saw_val   = {~u[W-1], u[W-2:0]};
    sq_val    = (phase_q[PW-1 -: 8] < bus.duty) ? {1'b0, {(W-1){1'b1}}}
                                                : {1'b1, {(W-1){1'b0}}};
    t         = phase_q[PW-1] ? ~phase_q[PW-2 -: W] : phase_q[PW-2 -: W];
    tri_val   = {~t[W-1], t[W-2:0]};
    noise_val = lfsr_q[15 -: W];
    wave_d    = saw_val;
    case (active_wave_q)
      WAVE_SAW:    wave_d = saw_val;
      WAVE_SQUARE: wave_d = sq_val;
      WAVE_TRI:    wave_d = tri_val;
      WAVE_NOISE:  wave_d = noise_val;
      default:     wave_d = saw_val;
    endcase
  end

  // Volume is strictly below 2**VW, so the shifted product always fits back into W bits.
  assign prod     = $signed({{(VW+1){s1_wave_q[W-1]}}, s1_wave_q}) *
                    $signed({{W{1'b0}}, 1'b0, bus.vol});
  assign scaled_d = W'(prod >>> VW) + MID;

  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      phase_q       <= '0;
      active_wave_q <= WAVE_SAW;
      lfsr_q        <= 16'hACE1;
      s1_wave_q     <= '0;
      s1_valid_q    <= 1'b0;
      wave_out_q    <= MID;
      out_valid_q   <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      s1_valid_q <= bus.sample_en;
      if (bus.sample_en) begin
        s1_wave_q <= wave_d;
      end
      // Sync has priority over the advance; waveform changes otherwise wait for a carry.
      if (bus.sync) begin
        phase_q       <= '0;
        active_wave_q <= wave_e'(bus.wave_sel);
        wrap_q        <= 1'b0;
      end else if (bus.sample_en) begin
        phase_q <= sum_d[PW-1:0];
        wrap_q  <= sum_d[PW];
        if (sum_d[PW]) begin
          active_wave_q <= wave_e'(bus.wave_sel);
          lfsr_q        <= lfsr_d;
        end
      end else begin
        wrap_q <= 1'b0;
      end
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        wave_out_q <= scaled_d;
      end
    end
  end

  assign bus.wave_out  = wave_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.wrap      = wrap_q;
  assign bus.phase_out = phase_q;

endmodule
